// File: rtl/wm8960_cfg_pkg.sv
// WM8960 config scheduler: shared states and default table slices.
// Build option: CFG_SCHED_RETRY_EN enables per-entry NACK retries.
package wm8960_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_NEXT
  } state_e;

  localparam logic [7:0] WM8960_DEV_ID = 8'h34;

  localparam logic [31:0] DEF_SEQ_START =
    {8'd18, 8'd0, 8'd0, 8'd0};
  localparam logic [31:0] DEF_SEQ_LEN =
    {8'd2, 8'd18, 8'd18, 8'd18};

  localparam int DEF_MAX_RETRY = 3;

endpackage

// File: rtl/cfg_prio_pick.sv
// Lowest-index-first priority pick over the pending flags.
// Build option: none (CFG_SCHED_RETRY_EN lives in the top).
module cfg_prio_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  pend_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_i[i]) begin
        any_o = 1'b1;
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/wm8960_cfg_sched.sv
// Fixed-priority scheduler feeding the WM8960 I2C write engine.
// Build option: CFG_SCHED_RETRY_EN (retry NACKed entries, then skip).
module wm8960_cfg_sched
  import wm8960_cfg_pkg::*;
#(
  parameter int                 N_REQ     = 4,
  parameter logic [8*N_REQ-1:0] SEQ_START = DEF_SEQ_START,
  parameter logic [8*N_REQ-1:0] SEQ_LEN   = DEF_SEQ_LEN,
  parameter logic [7:0]         DEV_ID    = WM8960_DEV_ID,
  parameter int                 MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             busy,
  output logic [1:0]       grant_id,
  output logic             seq_done,
  output logic             seq_err,
  output logic [7:0]       tbl_addr,
  input  logic [15:0]      tbl_q,
  output logic             wrreg_req,
  output logic [7:0]       reg_addr,
  output logic [7:0]       wrdata,
  output logic [7:0]       device_id,
  input  logic             RW_Done,
  input  logic             ack
);

`ifdef CFG_SCHED_RETRY_EN
  localparam int TRIES = (MAX_RETRY < 1) ? 1 : MAX_RETRY;
`else
  localparam int TRIES = 1;
`endif
  localparam int TW = $clog2(MAX_RETRY + 1);

  state_e           state_q;
  logic [N_REQ-1:0] pend_q;
  logic [7:0]       idx_q;
  logic [7:0]       n_q;
  logic [7:0]       len_q;
  logic [TW-1:0]    try_q;
  logic             busy_q;
  logic [1:0]       gid_q;
  logic             done_q;
  logic             err_q;
  logic             wr_q;
  logic [7:0]       raddr_q;
  logic [7:0]       wdata_q;

  logic             any;
  logic [1:0]       pick;
  logic [N_REQ-1:0] clr;
  logic [7:0]       pick_len;

  cfg_prio_pick #(
    .N  (N_REQ),
    .IW (2)
  ) u_pick (
    .pend_i (pend_q),
    .any_o  (any),
    .idx_o  (pick)
  );

  assign clr      = N_REQ'(1) << pick;
  assign pick_len = SEQ_LEN[8*pick +: 8];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      len_q   <= '0;
      try_q   <= '0;
      busy_q  <= 1'b0;
      gid_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      raddr_q <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      wr_q   <= 1'b0;
      pend_q <= pend_q | req;
      unique case (state_q)
        S_IDLE: begin
          // busy_q still high here means a sequence just ended
          busy_q <= 1'b0;
          if (any && !busy_q) begin
            pend_q <= (pend_q & ~clr) | req;
            gid_q  <= pick;
            idx_q  <= SEQ_START[8*pick +: 8];
            len_q  <= pick_len;
            n_q    <= '0;
            try_q  <= '0;
            if (pick_len == 8'd0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          raddr_q <= tbl_q[15:8];
          wdata_q <= tbl_q[7:0];
          wr_q    <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (RW_Done) begin
            if (!ack) begin
              state_q <= S_NEXT;
            end else if (32'(try_q) + 1 < TRIES) begin
              try_q   <= try_q + TW'(1);
              state_q <= S_LATCH;
            end else begin
              err_q <= 1'b1;
`ifdef CFG_SCHED_RETRY_EN
              state_q <= S_NEXT;
`else
              state_q <= S_IDLE;
`endif
            end
          end
        end
        S_NEXT: begin
          try_q <= '0;
          if (n_q + 8'd1 == len_q) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            n_q     <= n_q + 8'd1;
            idx_q   <= idx_q + 8'd1;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign grant_id  = gid_q;
  assign seq_done  = done_q;
  assign seq_err   = err_q;
  assign tbl_addr  = idx_q;
  assign wrreg_req = wr_q;
  assign reg_addr  = raddr_q;
  assign wrdata    = wdata_q;
  assign device_id = DEV_ID;

endmodule

// File: tb/tb_wm8960_cfg_sched.sv
// Directed/random bench for wm8960_cfg_sched with an I2C responder.
// Build option: CFG_SCHED_RETRY_EN changes the NACK expectations.
module tb_wm8960_cfg_sched;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic        busy;
  logic [1:0]  grant_id;
  logic        seq_done;
  logic        seq_err;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_q = '0;
  logic        wrreg_req;
  logic [7:0]  reg_addr;
  logic [7:0]  wrdata;
  logic [7:0]  device_id;
  logic        RW_Done = 1'b0;
  logic        ack = 1'b0;

  wm8960_cfg_sched #(
    .N_REQ     (4),
    .SEQ_START ({8'd18, 8'd0, 8'd0, 8'd0}),
    .SEQ_LEN   ({8'd2, 8'd0, 8'd18, 8'd18}),
    .DEV_ID    (8'h34),
    .MAX_RETRY (3)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .req       (req),
    .busy      (busy),
    .grant_id  (grant_id),
    .seq_done  (seq_done),
    .seq_err   (seq_err),
    .tbl_addr  (tbl_addr),
    .tbl_q     (tbl_q),
    .wrreg_req (wrreg_req),
    .reg_addr  (reg_addr),
    .wrdata    (wrdata),
    .device_id (device_id),
    .RW_Done   (RW_Done),
    .ack       (ack)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Register table as seen by the scheduler: one-cycle read latency.
  logic [15:0] tbl_mem [256];
  always_ff @(posedge Clk) tbl_q <= tbl_mem[tbl_addr];

  // Model of each requester's slice, taken directly from the parameters.
  int ST [4] = '{0, 0, 0, 18};
  int LN [4] = '{18, 18, 0, 2};

  int checks = 0;
  int failures = 0;

  logic [15:0] w_log[$];
  int          w_cyc[$];
  int          w_gid[$];
  int          d_cyc[$];
  int          d_gid[$];
  int          n_err = 0;
  bit          busy_hist[int];

  logic        ack_q[$];
  bit          resp_hold = 1'b0;

  logic [15:0] exp_w[$];
  int          exp_wg[$];
  int          exp_dg[$];
  int          exp_d = 0;
  int          exp_e = 0;
  int          wbase = 0;
  int          dbase = 0;

  always @(negedge Clk) begin
    if (Rst_n) begin
      busy_hist[cyc] = busy;
      if (wrreg_req) begin
        w_log.push_back({reg_addr, wrdata});
        w_cyc.push_back(cyc);
        w_gid.push_back(int'(grant_id));
      end
      if (seq_done) begin
        d_cyc.push_back(cyc);
        d_gid.push_back(int'(grant_id));
      end
      if (seq_err) n_err++;
    end
  end

  // I2C engine stand-in: answers each write after 1..4 cycles.
  initial begin : responder
    int d;
    forever begin
      @(negedge Clk);
      if (Rst_n && wrreg_req && !resp_hold) begin
        d = $urandom_range(1, 4);
        repeat (d) @(negedge Clk);
        RW_Done = 1'b1;
        ack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
        @(negedge Clk);
        RW_Done = 1'b0;
        ack = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_seq(input int r, input int nack_j);
    logic [15:0] e;
    for (int j = 0; j < LN[r]; j++) begin
      e = tbl_mem[(ST[r] + j) % 256];
      if (j == nack_j) begin
`ifdef CFG_SCHED_RETRY_EN
        repeat (3) begin
          exp_w.push_back(e);
          exp_wg.push_back(r);
        end
        exp_e++;
`else
        exp_w.push_back(e);
        exp_wg.push_back(r);
        exp_e++;
        return;
`endif
      end else begin
        exp_w.push_back(e);
        exp_wg.push_back(r);
      end
    end
    exp_d++;
    exp_dg.push_back(r);
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, "_wr_cnt"}, w_log.size() - wbase, exp_w.size());
    for (int i = 0; i < exp_w.size(); i++) begin
      if (wbase + i < w_log.size()) begin
        chk($sformatf("%s_wr%0d", tag, i), w_log[wbase + i], exp_w[i]);
        chk($sformatf("%s_gid%0d", tag, i), w_gid[wbase + i], exp_wg[i]);
      end
    end
    chk({tag, "_done_cnt"}, d_cyc.size(), exp_d);
    chk({tag, "_err_cnt"}, n_err, exp_e);
    for (int i = 0; i < exp_dg.size(); i++) begin
      if (dbase + i < d_gid.size())
        chk($sformatf("%s_dgid%0d", tag, i), d_gid[dbase + i], exp_dg[i]);
    end
    wbase = w_log.size();
    dbase = d_gid.size();
    exp_w.delete();
    exp_wg.delete();
    exp_dg.delete();
  endtask

  task automatic wait_wr(input string tag, input int target, input int budget);
    int b = budget;
    while (w_log.size() < target && b > 0) begin
      @(negedge Clk);
      b--;
    end
    chk({tag, "_wr_reached"}, w_log.size() >= target, 1);
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int b = budget;
    while (d_cyc.size() < target && b > 0) begin
      @(negedge Clk);
      b--;
    end
    chk({tag, "_done_reached"}, d_cyc.size() >= target, 1);
    repeat (3) @(negedge Clk);
  endtask

  task automatic pulse(input logic [3:0] m, output int c0);
    @(negedge Clk);
    c0 = cyc;
    req = m;
    @(negedge Clk);
    req = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_gid"}, grant_id, 2'd0);
    chk({tag, "_done"}, seq_done, 1'b0);
    chk({tag, "_err"}, seq_err, 1'b0);
    chk({tag, "_wr"}, wrreg_req, 1'b0);
    chk({tag, "_taddr"}, tbl_addr, 8'd0);
    chk({tag, "_raddr"}, reg_addr, 8'd0);
    chk({tag, "_wdata"}, wrdata, 8'd0);
  endtask

  initial begin : main
    int c;
    int k;
    for (int i = 0; i < 256; i++) tbl_mem[i] = 16'($urandom);

    // Reset state
    repeat (2) @(negedge Clk);
    chk_reset_vals("rst");
    chk("dev_id", device_id, 8'h34);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Single volume request: timing and two entries
    pulse(4'b1000, c);
    @(negedge Clk);
    chk("vol_taddr_c2", tbl_addr, 8'd18);
    chk("vol_busy_c2", busy, 1'b1);
    chk("vol_gid_c2", grant_id, 2'd3);
    add_seq(3, -1);
    wait_done("vol", exp_d, 200);
    chk("vol_first_wr_cyc", w_cyc[wbase], c + 4);
    chk("vol_busy_c1", busy_hist[c + 1], 1'b0);
    chk("vol_gid_end", grant_id, 2'd3);
    cmp_all("vol");

    // Simultaneous req[1] and req[3]
    pulse(4'b1010, c);
    add_seq(1, -1);
    add_seq(3, -1);
    wait_done("sim", exp_d, 2000);
    k = d_cyc[dbase];
    chk("sim_busy_k", busy_hist[k], 1'b1);
    chk("sim_busy_k1", busy_hist[k + 1], 1'b0);
    chk("sim_busy_k2", busy_hist[k + 2], 1'b1);
    chk("sim_2nd_wr_cyc", w_cyc[wbase + 18], k + 4);
    cmp_all("sim");

    // Rerun: req during own sequence queues exactly one rerun
    pulse(4'b1000, c);
    wait_wr("rr1", wbase + 1, 100);
    pulse(4'b1000, c);
    wait_done("rr1", dbase + 1, 200);
    wait_wr("rr2", wbase + 3, 100);
    pulse(4'b1000, c);
    repeat (2) @(negedge Clk);
    pulse(4'b1000, c);
    add_seq(3, -1);
    add_seq(3, -1);
    add_seq(3, -1);
    wait_done("rr", dbase + 3, 400);
    repeat (100) @(negedge Clk);
    cmp_all("rr");

    // NACK on the second entry of requester 1
`ifdef CFG_SCHED_RETRY_EN
    ack_q = '{1'b0, 1'b1, 1'b1, 1'b1};
    pulse(4'b0010, c);
    add_seq(1, 1);
    wait_done("nack", exp_d, 3000);
`else
    ack_q = '{1'b0, 1'b1};
    pulse(4'b0010, c);
    add_seq(1, 1);
    begin
      int b = 300;
      while (n_err < exp_e && b > 0) begin
        @(negedge Clk);
        b--;
      end
    end
    repeat (60) @(negedge Clk);
    chk("nack_busy_low", busy, 1'b0);
`endif
    chk("nack_acks_used", ack_q.size(), 0);
    cmp_all("nack");

    // Reset while waiting on the I2C engine
    resp_hold = 1'b1;
    pulse(4'b0010, c);
    wait_wr("rw", wbase + 1, 100);
    pulse(4'b1000, c);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk_reset_vals("rw_rst");
    @(negedge Clk);
    Rst_n = 1'b1;
    resp_hold = 1'b0;
    wbase = w_log.size();
    dbase = d_gid.size();
    repeat (40) @(negedge Clk);
    chk("rw_no_pending", w_log.size(), wbase);
    pulse(4'b0001, c);
    @(negedge Clk);
    chk("rw_taddr_c2", tbl_addr, 8'd0);
    chk("rw_gid_c2", grant_id, 2'd0);
    chk("rw_busy_c2", busy, 1'b1);
    add_seq(0, -1);
    wait_done("rw", exp_d, 2000);
    chk("rw_first_wr_cyc", w_cyc[wbase], c + 4);
    cmp_all("rw");

    // Zero-length slice
    pulse(4'b0100, c);
    @(negedge Clk);
    chk("z_gid", grant_id, 2'd2);
    exp_d++;
    exp_dg.push_back(2);
    wait_done("z", exp_d, 20);
    chk("z_done_cyc", d_cyc[dbase], c + 2);
    chk("z_busy_c1", busy_hist[c + 1], 1'b0);
    chk("z_busy_c2", busy_hist[c + 2], 1'b0);
    cmp_all("z");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wm8960_cfg_sched.md
# wm8960_cfg_sched

Request scheduler for the WM8960 codec's single I2C register-write engine. It collects update requests from up to N_REQ independent sources (full init, volume, mic-bias, BCLK) as sticky pending flags and grants them one at a time in fixed priority. For each granted request it walks that source's slice of the register table, issuing one write per entry with NACK handling. It sits between the control logic and the `i2c_control` instance, and replaces the ad-hoc counter-reload sequencing.

## Interface
Parameters:
- N_REQ, 4, number of requesters; index 0 has highest priority.
- SEQ_START, {8'd18,8'd0,8'd0,8'd0}, packed 8-bit table start index per requester; requester 0 occupies the LSB byte.
- SEQ_LEN, {8'd2,8'd18,8'd18,8'd18}, packed 8-bit entry count per requester.
- DEV_ID, 8'h34, I2C device address driven on device_id.
- MAX_RETRY, 3, write attempts per entry (only with CFG_SCHED_RETRY_EN).

Ports:
- Clk  in  1  clock.
- Rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-source request pulse; level is tolerated and re-arms each cycle.
- busy  out  1  high from grant until the sequence ends.
- grant_id  out  2  index of the active or last requester.
- seq_done  out  1  1-cycle pulse when a sequence completes.
- seq_err  out  1  1-cycle pulse at an abandoned entry or aborted sequence.
- tbl_addr  out  8  register-table read index.
- tbl_q  in  16  table data {reg_addr, wrdata}, valid 1 cycle after tbl_addr.
- wrreg_req  out  1  1-cycle write strobe to the I2C engine.
- reg_addr  out  8  register address.
- wrdata  out  8  register data.
- device_id  out  8  constant DEV_ID.
- RW_Done  in  1  I2C transfer finished (1-cycle pulse).
- ack  in  1  valid with RW_Done; 0 = ACK, 1 = NACK.

## Operation
- pending[i] is set on req[i]=1 and cleared only when requester i is granted. A req for the active requester during its sequence re-sets pending, so the sequence reruns afterwards with the latest table contents (e.g. a new volume).
- States:
  - IDLE: if any pending bit is set, grant the lowest set index, clear that bit, set idx=SEQ_START[i] and n=0, then go to FETCH. If SEQ_LEN[i]==0, pulse seq_done instead and stay in IDLE.
  - FETCH: tbl_addr=idx. Go to LATCH.
  - LATCH: register tbl_q into reg_addr/wrdata, set wrreg_req, go to ISSUE.
  - ISSUE: wrreg_req is high for this single cycle. Go to WAIT.
  - WAIT: hold until RW_Done. ack=0 goes to NEXT. ack=1 is handled per Configuration.
  - NEXT: if n+1==SEQ_LEN, pulse seq_done and go to IDLE. Otherwise increment idx and n, then go to FETCH.
- No preemption. A higher-priority req arriving mid-sequence waits for the current sequence to end.
- idx and n are 8-bit. idx wraps modulo 256 with no check, so table layout is the integrator's responsibility.
- Reset values: busy=0, grant_id=0, seq_done=0, seq_err=0, wrreg_req=0, tbl_addr=0, reg_addr=0, wrdata=0, pending=0, state IDLE.
- Reset mid-transfer aborts immediately and the I2C engine is reset in parallel. No pending flag survives reset.

## Timing
- req[i] in cycle 0 gives pending in cycle 1, grant and FETCH in cycle 2, LATCH in cycle 3, and wrreg_req high in cycle 4 when idle and no higher-priority request is pending.
- Per entry: 4 cycles plus the I2C transfer time.
- Back-to-back sequences: seq_done in cycle k, the next grant in cycle k+1, and busy stays low for exactly that one cycle.
- A RW_Done seen outside WAIT is ignored.
- busy is asserted in the cycle following the grant decision and remains high through the cycle that carries seq_done or the abort seq_err.

## Configuration
- CFG_SCHED_RETRY_EN defined:
  - A NACK returns to LATCH and rewrites the entry, up to MAX_RETRY total attempts.
  - After the final NACK, pulse seq_err and continue to NEXT; the entry is skipped and the sequence proceeds.
- Undefined:
  - The first NACK pulses seq_err and returns to IDLE, abandoning the rest of the sequence (busy drops).
  - pending is not re-set by the abort.

## Structure
- Package wm8960_cfg_pkg holds the state enum, default SEQ_START/SEQ_LEN slices, and the WM8960 device address constant.
- Sub-module cfg_prio_pick: a combinational lowest-index-first priority encoder producing {any, index} from pending. This is the only natural split.

## Test plan
- Single volume request: req[3] pulse with SEQ_START=18 and SEQ_LEN=2 -> tbl_addr 18 then 19, two wrreg_req pulses (first in cycle 4), seq_done, grant_id=3.
- Simultaneous req[1] and req[3] -> the req[1] sequence of 18 writes completes first, then the req[3] sequence; one idle cycle separates them.
- req[3] pulse during its own sequence -> the sequence reruns once after completion; a third pulse during the rerun queues one more rerun, never more.
- NACK on the 2nd entry:
  - With CFG_SCHED_RETRY_EN: 3 write attempts, seq_err pulse, remaining entries still written, seq_done.
  - Without it: seq_err, return to IDLE, no further wrreg_req.
- Rst_n asserted in WAIT -> all outputs at reset values, pending cleared; a subsequent req[0] restarts from SEQ_START[0].
- SEQ_LEN[2]=0 with req[2] -> seq_done one cycle after pending, no wrreg_req.
